// File: rtl/multiplexer_pkg.sv
// Shared types for the arbitrated multiplexer: arbitration mode and packet-lock state.
package multiplexer_pkg;

  typedef enum logic {
    MUX_ROUND_ROBIN,
    MUX_FIXED
  } mux_mode_t;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } mux_lock_state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, with wrap-around.
module round_robin_arbiter #(
  parameter int unsigned SELECT_WIDTH = 2
) (
  input  logic [(2**SELECT_WIDTH)-1:0] request,
  input  logic [SELECT_WIDTH-1:0]      rr_ptr,
  output logic [SELECT_WIDTH-1:0]      grant,
  output logic                         grant_valid
);

  localparam int unsigned N = 2**SELECT_WIDTH;

  logic [SELECT_WIDTH-1:0] w_idx;

  // The index sum wraps naturally at SELECT_WIDTH bits, giving the circular search order.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = rr_ptr + SELECT_WIDTH'(k);
      if (!grant_valid && request[w_idx]) begin
        grant       = w_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// Registered N-to-1 multiplexer with valid/ready handshakes, round-robin or fixed arbitration,
// and packet locking so multi-beat packets are never interleaved.
module arbitrated_multiplexer
  import multiplexer_pkg::*;
#(
  parameter int unsigned SELECT_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic [SELECT_WIDTH-1:0]       control_signals,
  input  logic [(2**SELECT_WIDTH)-1:0]  in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data [2**SELECT_WIDTH],
  input  logic [(2**SELECT_WIDTH)-1:0]  in_last,
  output logic [(2**SELECT_WIDTH)-1:0]  in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SELECT_WIDTH-1:0]       out_channel,
  input  logic                          out_ready
);

  mux_lock_state_t         r_state;
  mux_lock_state_t         w_state_next;
  mux_mode_t               r_lock_mode;
  mux_mode_t               w_mode_eff;
  logic [SELECT_WIDTH-1:0] r_lock_owner;
  logic [SELECT_WIDTH-1:0] r_rr_ptr;

  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_last;
  logic [SELECT_WIDTH-1:0] r_out_channel;

  logic [SELECT_WIDTH-1:0] w_rr_grant;
  logic                    w_rr_grant_valid;
  logic [SELECT_WIDTH-1:0] w_grant;
  logic                    w_grant_valid;
  logic                    w_space;
  logic                    w_accept;
  logic                    w_last_beat;

  round_robin_arbiter #(
    .SELECT_WIDTH(SELECT_WIDTH)
  ) u_rr_arbiter (
    .request    (in_valid),
    .rr_ptr     (r_rr_ptr),
    .grant      (w_rr_grant),
    .grant_valid(w_rr_grant_valid)
  );

  // While locked, the owner keeps the grant and the mode captured at packet start applies.
  always_comb begin
    w_mode_eff    = (r_state == LOCKED) ? r_lock_mode : mux_mode_t'(mode);
    w_grant       = w_rr_grant;
    w_grant_valid = w_rr_grant_valid;
    if (r_state == LOCKED) begin
      w_grant       = r_lock_owner;
      w_grant_valid = in_valid[r_lock_owner];
    end else if (w_mode_eff == MUX_FIXED) begin
      w_grant       = control_signals;
      w_grant_valid = in_valid[control_signals];
    end
  end

  assign w_space     = !r_out_valid || out_ready;
  assign w_accept    = w_space && w_grant_valid && !reset;
  assign w_last_beat = in_last[w_grant];

  always_comb begin
    in_ready = '0;
    if (w_accept) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      UNLOCKED: if (w_accept && !w_last_beat) w_state_next = LOCKED;
      LOCKED:   if (w_accept && w_last_beat)  w_state_next = UNLOCKED;
      default:  w_state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= UNLOCKED;
      r_lock_owner <= '0;
      r_lock_mode  <= MUX_ROUND_ROBIN;
      r_rr_ptr     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == UNLOCKED && w_accept && !w_last_beat) begin
        r_lock_owner <= w_grant;
        r_lock_mode  <= w_mode_eff;
      end
      if (w_accept && w_last_beat) begin
        r_rr_ptr <= w_grant + SELECT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_channel <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= in_data[w_grant];
      r_out_last    <= w_last_beat;
      r_out_channel <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_channel = r_out_channel;

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Scoreboard bench for arbitrated_multiplexer: directed packets per channel, expected beats
// queued up front and checked by an independent output monitor.
module tb_arbitrated_multiplexer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] cs;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_channel;
  logic       out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0]  src_q [4][$];   // {last, data}
  logic [10:0] sb_q [$];       // {channel, last, data}
  int          pop_cyc [$];
  logic [3:0]  last_ready;

  arbitrated_multiplexer #(
    .SELECT_WIDTH(2),
    .DATA_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .control_signals(cs),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_channel    (out_channel),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic send(input int ch, input logic [7:0] d, input logic l);
    src_q[ch].push_back({l, d});
  endtask

  task automatic expect_beat(input int ch, input logic [7:0] d, input logic l);
    sb_q.push_back({2'(ch), l, d});
  endtask

  task automatic drive_inputs();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        h           = src_q[i][0];
        in_valid[i] = 1'b1;
        in_last[i]  = h[8];
        in_data[i]  = h[7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i]  = 8'h00;
      end
    end
  endtask

  // Inputs change only at the falling edge, so the handshake seen just after it holds at posedge.
  task automatic cycle(input logic ordy);
    logic [3:0] fire;
    @(negedge clk);
    drive_inputs();
    out_ready = ordy;
    #1;
    last_ready = in_ready;
    fire       = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) void'(src_q[i].pop_front());
    end
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (sb_q.size() == 0);
    for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (!all_idle() && n < 100) begin
      cycle(1'b1);
      n++;
    end
    total++;
    if (!all_idle()) begin
      bad++;
      $display("FAIL %s_drain: timeout with %0d beats still expected", name, sb_q.size());
    end
  endtask

  task automatic check_contig(input string name, input int first, input int n);
    if (pop_cyc.size() < first + n) begin
      total++;
      bad++;
      $display("FAIL %s_contig: got %0d beats required %0d", name, pop_cyc.size() - first, n);
    end else begin
      check({name, "_contig"}, 32'(pop_cyc[first+n-1] - pop_cyc[first]), 32'(n - 1));
    end
  endtask

  // Output monitor: a transfer happens at the next posedge whenever valid and ready are high.
  initial begin
    logic [10:0] got;
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got = {out_channel, out_last, out_data};
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h required none", got);
        end else begin
          exp = sb_q.pop_front();
          check("beat", 32'(got), 32'(exp));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset     = 1'b1;
    mode      = 1'b0;
    cs        = 2'd0;
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 8'hA0 + 8'(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_channel", 32'(out_channel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 4'h0;
    reset    = 1'b0;

    // Round-robin fairness from rr_ptr = 0.
    b0 = pop_cyc.size();
    send(0, 8'h00, 1'b1); send(1, 8'h01, 1'b1); send(2, 8'h02, 1'b1);
    send(3, 8'h03, 1'b1); send(0, 8'h00, 1'b1);
    expect_beat(0, 8'h00, 1'b1); expect_beat(1, 8'h01, 1'b1); expect_beat(2, 8'h02, 1'b1);
    expect_beat(3, 8'h03, 1'b1); expect_beat(0, 8'h00, 1'b1);
    drain("rr");
    check_contig("rr", b0, 5);

    // Packet lock on channel 1 (rr_ptr = 1), then channel 2, then channel 0.
    b0 = pop_cyc.size();
    send(1, 8'h11, 1'b0); send(1, 8'h12, 1'b0); send(1, 8'h13, 1'b1);
    send(0, 8'h05, 1'b1); send(2, 8'h20, 1'b1);
    expect_beat(1, 8'h11, 1'b0); expect_beat(1, 8'h12, 1'b0); expect_beat(1, 8'h13, 1'b1);
    expect_beat(2, 8'h20, 1'b1); expect_beat(0, 8'h05, 1'b1);
    drain("lock");
    check_contig("lock", b0, 5);

    // Fixed mode on channel 2; mode flips to round-robin mid-packet.
    b0   = pop_cyc.size();
    mode = 1'b1;
    cs   = 2'd2;
    send(0, 8'h30, 1'b1);
    send(2, 8'h41, 1'b0); send(2, 8'h42, 1'b0); send(2, 8'h43, 1'b1);
    expect_beat(2, 8'h41, 1'b0); expect_beat(2, 8'h42, 1'b0); expect_beat(2, 8'h43, 1'b1);
    expect_beat(0, 8'h30, 1'b1);
    cycle(1'b1);
    check("fixed_ready", 32'(last_ready), 32'h4);
    mode = 1'b0;
    drain("fixed");
    check_contig("fixed", b0, 4);

    // Fixed mode selecting an idle channel grants nothing.
    mode = 1'b1;
    cs   = 2'd3;
    send(1, 8'h55, 1'b1);
    expect_beat(1, 8'h55, 1'b1);
    repeat (3) begin
      cycle(1'b1);
      check("fixed_idle_ready", 32'(last_ready), 32'h0);
    end
    check("fixed_idle_pending", 32'(src_q[1].size()), 32'd1);
    mode = 1'b0;
    drain("fixed_idle");

    // Backpressure: output holds and all in_ready stay low.
    send(2, 8'h61, 1'b1); send(2, 8'h62, 1'b1); send(2, 8'h63, 1'b1);
    expect_beat(2, 8'h61, 1'b1); expect_beat(2, 8'h62, 1'b1); expect_beat(2, 8'h63, 1'b1);
    cycle(1'b0);
    check("bp_first", 32'(out_data), 32'h61);
    repeat (3) begin
      cycle(1'b0);
      check("bp_ready", 32'(last_ready), 32'h0);
      check("bp_hold", 32'({out_valid, out_data}), 32'h161);
    end
    drain("bp");

    // Asynchronous reset mid-packet drops the beat and the lock.
    send(3, 8'h71, 1'b0);
    cycle(1'b0);
    check("pre_rst_out", 32'({out_valid, out_data}), 32'h171);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    void'(src_q[3].pop_front());
    @(negedge clk);
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      cycle(1'b1);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(1, 8'h81, 1'b1); send(0, 8'h90, 1'b1);
    expect_beat(0, 8'h90, 1'b1); expect_beat(1, 8'h81, 1'b1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
